// File: rtl/iob_axi_m_bridge_if.sv
// iob_axi_m_bridge_if: native IOb request port plus the AXI4 master port of
// the bridge, bundled together. The master modport is the bridge's view
// (native slave, AXI master); the slave modport is the surrounding system.
interface iob_axi_m_bridge_if #(
    parameter int ADDR_W   = 30,
    parameter int DATA_W   = 32,
    parameter int AXI_ID_W = 1
);
    // native side
    logic                req_valid;
    logic [ADDR_W-1:0]   req_addr;
    logic [DATA_W-1:0]   req_wdata;
    logic [3:0]          req_wstrb;
    logic [DATA_W-1:0]   req_rdata;
    logic                req_ready;
    logic                err;
    logic [ADDR_W-1:0]   err_addr;

    // AXI write address
    logic [AXI_ID_W-1:0] m_axi_awid;
    logic [ADDR_W-1:0]   m_axi_awaddr;
    logic [7:0]          m_axi_awlen;
    logic [2:0]          m_axi_awsize;
    logic [1:0]          m_axi_awburst;
    logic                m_axi_awlock;
    logic [3:0]          m_axi_awcache;
    logic [2:0]          m_axi_awprot;
    logic [3:0]          m_axi_awqos;
    logic                m_axi_awvalid;
    logic                m_axi_awready;

    // AXI write data / response
    logic [DATA_W-1:0]   m_axi_wdata;
    logic [3:0]          m_axi_wstrb;
    logic                m_axi_wlast;
    logic                m_axi_wvalid;
    logic                m_axi_wready;
    logic [1:0]          m_axi_bresp;
    logic                m_axi_bvalid;
    logic                m_axi_bready;

    // AXI read address
    logic [AXI_ID_W-1:0] m_axi_arid;
    logic [ADDR_W-1:0]   m_axi_araddr;
    logic [7:0]          m_axi_arlen;
    logic [2:0]          m_axi_arsize;
    logic [1:0]          m_axi_arburst;
    logic                m_axi_arlock;
    logic [3:0]          m_axi_arcache;
    logic [2:0]          m_axi_arprot;
    logic [3:0]          m_axi_arqos;
    logic                m_axi_arvalid;
    logic                m_axi_arready;

    // AXI read data
    logic [DATA_W-1:0]   m_axi_rdata;
    logic [1:0]          m_axi_rresp;
    logic                m_axi_rlast;
    logic                m_axi_rvalid;
    logic                m_axi_rready;

    modport master (
        input  req_valid, req_addr, req_wdata, req_wstrb,
        output req_rdata, req_ready, err, err_addr,
        output m_axi_awid, m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst,
               m_axi_awlock, m_axi_awcache, m_axi_awprot, m_axi_awqos, m_axi_awvalid,
        input  m_axi_awready,
        output m_axi_wdata, m_axi_wstrb, m_axi_wlast, m_axi_wvalid,
        input  m_axi_wready,
        input  m_axi_bresp, m_axi_bvalid,
        output m_axi_bready,
        output m_axi_arid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst,
               m_axi_arlock, m_axi_arcache, m_axi_arprot, m_axi_arqos, m_axi_arvalid,
        input  m_axi_arready,
        input  m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid,
        output m_axi_rready
    );

    modport slave (
        output req_valid, req_addr, req_wdata, req_wstrb,
        input  req_rdata, req_ready, err, err_addr,
        input  m_axi_awid, m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst,
               m_axi_awlock, m_axi_awcache, m_axi_awprot, m_axi_awqos, m_axi_awvalid,
        output m_axi_awready,
        input  m_axi_wdata, m_axi_wstrb, m_axi_wlast, m_axi_wvalid,
        output m_axi_wready,
        output m_axi_bresp, m_axi_bvalid,
        input  m_axi_bready,
        input  m_axi_arid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst,
               m_axi_arlock, m_axi_arcache, m_axi_arprot, m_axi_arqos, m_axi_arvalid,
        output m_axi_arready,
        output m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid,
        input  m_axi_rready
    );
endinterface

// File: rtl/iob_axi_m_bridge.sv
// iob_axi_m_bridge: turns single-word native requests into single-beat AXI4
// transactions, one in flight at a time. Optional error capture (sticky err
// flag plus first failing address) is built when IOB_AXI_BRIDGE_ERR_EN is
// defined; otherwise err/err_addr stay 0 and responses are ignored.
module iob_axi_m_bridge #(
    parameter int ADDR_W   = 30,
    parameter int DATA_W   = 32,
    parameter int AXI_ID_W = 1,
    parameter int AXI_ID   = 0
) (
    input logic                clk,
    input logic                rst,
    iob_axi_m_bridge_if.master bus
);
    typedef enum logic [2:0] {IDLE, WRITE, WRESP, READ, RDATA, DONE} state_t;

    state_t              state_reg, state_next;
    logic [ADDR_W-3:0]   addr_reg, addr_next;        // word address
    logic [DATA_W-1:0]   wdata_reg, wdata_next;
    logic [3:0]          wstrb_reg, wstrb_next;
    logic                awvalid_reg, awvalid_next;
    logic                wvalid_reg, wvalid_next;
    logic                arvalid_reg, arvalid_next;
    logic                req_ready_reg, req_ready_next;
    logic [DATA_W-1:0]   rdata_reg, rdata_next;
    logic                err_reg, err_next;
    logic [ADDR_W-1:0]   err_addr_reg, err_addr_next;
    logic                resp_bad;
    logic                unused_bits;

    // State and all registered outputs; reset aborts any transaction at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            addr_reg      <= '0;
            wdata_reg     <= '0;
            wstrb_reg     <= '0;
            awvalid_reg   <= 1'b0;
            wvalid_reg    <= 1'b0;
            arvalid_reg   <= 1'b0;
            req_ready_reg <= 1'b0;
            rdata_reg     <= '0;
            err_reg       <= 1'b0;
            err_addr_reg  <= '0;
        end else begin
            state_reg     <= state_next;
            addr_reg      <= addr_next;
            wdata_reg     <= wdata_next;
            wstrb_reg     <= wstrb_next;
            awvalid_reg   <= awvalid_next;
            wvalid_reg    <= wvalid_next;
            arvalid_reg   <= arvalid_next;
            req_ready_reg <= req_ready_next;
            rdata_reg     <= rdata_next;
            err_reg       <= err_next;
            err_addr_reg  <= err_addr_next;
        end
    end

    // Next-state and next-output decode. Each AXI valid is cleared after its
    // own handshake, so a low valid in WRITE means that channel is finished.
    always_comb begin
        state_next     = state_reg;
        addr_next      = addr_reg;
        wdata_next     = wdata_reg;
        wstrb_next     = wstrb_reg;
        awvalid_next   = awvalid_reg;
        wvalid_next    = wvalid_reg;
        arvalid_next   = arvalid_reg;
        req_ready_next = 1'b0;
        rdata_next     = rdata_reg;
        err_next       = err_reg;
        err_addr_next  = err_addr_reg;
        resp_bad       = 1'b0;
        case (state_reg)
            IDLE: begin
                if (bus.req_valid) begin
                    addr_next  = bus.req_addr[ADDR_W-1:2];
                    wdata_next = bus.req_wdata;
                    wstrb_next = bus.req_wstrb;
                    if (bus.req_wstrb != 4'b0000) begin
                        state_next   = WRITE;
                        awvalid_next = 1'b1;
                        wvalid_next  = 1'b1;
                    end else begin
                        state_next   = READ;
                        arvalid_next = 1'b1;
                    end
                end
            end
            WRITE: begin
                if (awvalid_reg && bus.m_axi_awready) awvalid_next = 1'b0;
                if (wvalid_reg && bus.m_axi_wready)   wvalid_next  = 1'b0;
                if (!awvalid_next && !wvalid_next)    state_next   = WRESP;
            end
            WRESP: begin
                if (bus.m_axi_bvalid) begin
                    state_next     = DONE;
                    req_ready_next = 1'b1;
                    resp_bad       = (bus.m_axi_bresp != 2'b00);
                end
            end
            READ: begin
                if (bus.m_axi_arready) begin
                    arvalid_next = 1'b0;
                    state_next   = RDATA;
                end
            end
            RDATA: begin
                if (bus.m_axi_rvalid) begin
                    rdata_next     = bus.m_axi_rdata;
                    state_next     = DONE;
                    req_ready_next = 1'b1;
                    resp_bad       = (bus.m_axi_rresp != 2'b00);
                end
            end
            DONE: begin
                // req_valid is deliberately not looked at here
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
`ifdef IOB_AXI_BRIDGE_ERR_EN
        if (resp_bad && !err_reg) begin
            err_next      = 1'b1;
            err_addr_next = {addr_reg, 2'b00};
        end
`endif
    end

`ifdef IOB_AXI_BRIDGE_ERR_EN
    assign unused_bits = ^{bus.m_axi_rlast, bus.req_addr[1:0]};
`else
    assign unused_bits = ^{bus.m_axi_rlast, bus.req_addr[1:0], resp_bad};
`endif

    // constant AXI attributes: single 32-bit INCR beat, modifiable/bufferable
    assign bus.m_axi_awid    = AXI_ID_W'(AXI_ID);
    assign bus.m_axi_awaddr  = {addr_reg, 2'b00};
    assign bus.m_axi_awlen   = 8'd0;
    assign bus.m_axi_awsize  = 3'd2;
    assign bus.m_axi_awburst = 2'b01;
    assign bus.m_axi_awlock  = 1'b0;
    assign bus.m_axi_awcache = 4'b0011;
    assign bus.m_axi_awprot  = 3'b010;
    assign bus.m_axi_awqos   = 4'd0;
    assign bus.m_axi_awvalid = awvalid_reg;

    assign bus.m_axi_wdata   = wdata_reg;
    assign bus.m_axi_wstrb   = wstrb_reg;
    assign bus.m_axi_wlast   = 1'b1;
    assign bus.m_axi_wvalid  = wvalid_reg;
    assign bus.m_axi_bready  = (state_reg == WRESP);

    assign bus.m_axi_arid    = AXI_ID_W'(AXI_ID);
    assign bus.m_axi_araddr  = {addr_reg, 2'b00};
    assign bus.m_axi_arlen   = 8'd0;
    assign bus.m_axi_arsize  = 3'd2;
    assign bus.m_axi_arburst = 2'b01;
    assign bus.m_axi_arlock  = 1'b0;
    assign bus.m_axi_arcache = 4'b0011;
    assign bus.m_axi_arprot  = 3'b010;
    assign bus.m_axi_arqos   = 4'd0;
    assign bus.m_axi_arvalid = arvalid_reg;
    assign bus.m_axi_rready  = (state_reg == RDATA);

    assign bus.req_rdata     = rdata_reg;
    assign bus.req_ready     = req_ready_reg;
    assign bus.err           = err_reg;
    assign bus.err_addr      = err_addr_reg;
endmodule

// File: tb/tb_iob_axi_m_bridge.sv
// tb_iob_axi_m_bridge: drives native requests into the bridge, emulates an
// AXI memory slave with programmable per-channel wait states, and compares
// results against a byte-lane memory model and latency formulas.
module tb_iob_axi_m_bridge;
`ifdef IOB_AXI_BRIDGE_ERR_EN
    localparam bit ERR_ON = 1'b1;
`else
    localparam bit ERR_ON = 1'b0;
`endif

    logic clk;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    iob_axi_m_bridge_if #(.ADDR_W(30), .DATA_W(32), .AXI_ID_W(1)) bus ();

    iob_axi_m_bridge #(.ADDR_W(30), .DATA_W(32), .AXI_ID_W(1), .AXI_ID(0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // slave configuration (written by the test, read by the slave)
    int aw_delay = 0, w_delay = 0, b_delay = 0, ar_delay = 0, r_delay = 0;
    logic [1:0] bresp_cfg = 2'b00, rresp_cfg = 2'b00;

    // slave bookkeeping
    logic [31:0] mem [int];
    int aw_count = 0, w_count = 0, ar_count = 0, proto_err = 0, cyc = 0;
    int aw_cyc = 0, w_cyc = 0;
    logic [29:0] cap_awaddr, cap_araddr, r_addr;
    logic [31:0] cap_wdata, cap_awmeta, cap_armeta;
    logic [3:0]  cap_wstrb;
    logic        cap_wlast;
    bit aw_got, w_got, b_pend, r_pend;
    int aw_wait, w_wait, b_wait, ar_wait, r_wait;
    bit prev_awv, prev_aw_hs, prev_wv, prev_w_hs, prev_arv, prev_ar_hs;
    logic [29:0] prev_awaddr, prev_araddr;
    logic [31:0] prev_wdata;
    logic [3:0]  prev_wstrb;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    function automatic logic [31:0] rd_mem(input int key);
        if (mem.exists(key)) return mem[key];
        return 32'h0;
    endfunction

    // AXI slave, evaluated on the falling edge: the next rising edge sees
    // exactly the values decided here, so handshakes are known in advance.
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            bus.m_axi_awready = 1'b0; bus.m_axi_wready = 1'b0; bus.m_axi_bvalid = 1'b0;
            bus.m_axi_bresp = 2'b00;  bus.m_axi_arready = 1'b0; bus.m_axi_rvalid = 1'b0;
            bus.m_axi_rdata = 32'h0;  bus.m_axi_rresp = 2'b00;  bus.m_axi_rlast = 1'b0;
            aw_got = 0; w_got = 0; b_pend = 0; r_pend = 0;
            aw_wait = 0; w_wait = 0; b_wait = 0; ar_wait = 0; r_wait = 0;
            prev_awv = 0; prev_aw_hs = 0; prev_wv = 0; prev_w_hs = 0; prev_arv = 0; prev_ar_hs = 0;
        end else begin
            // valids held with stable payload until handshake, dropped after it
            if (prev_awv && !prev_aw_hs && (!bus.m_axi_awvalid || bus.m_axi_awaddr !== prev_awaddr)) proto_err++;
            if (prev_wv && !prev_w_hs && (!bus.m_axi_wvalid || bus.m_axi_wdata !== prev_wdata ||
                                          bus.m_axi_wstrb !== prev_wstrb)) proto_err++;
            if (prev_arv && !prev_ar_hs && (!bus.m_axi_arvalid || bus.m_axi_araddr !== prev_araddr)) proto_err++;
            if (prev_aw_hs && bus.m_axi_awvalid) proto_err++;
            if (prev_w_hs && bus.m_axi_wvalid) proto_err++;
            if (prev_ar_hs && bus.m_axi_arvalid) proto_err++;
            prev_aw_hs = 0; prev_w_hs = 0; prev_ar_hs = 0;

            // B channel
            if (b_pend) begin
                bus.m_axi_bvalid = (b_wait >= b_delay);
                bus.m_axi_bresp  = bresp_cfg;
                if (bus.m_axi_bvalid && bus.m_axi_bready) b_pend = 0;
                else b_wait++;
            end else begin
                bus.m_axi_bvalid = 1'b0;
            end
            // R channel
            if (r_pend) begin
                bus.m_axi_rvalid = (r_wait >= r_delay);
                bus.m_axi_rdata  = rd_mem(int'(r_addr[29:2]));
                bus.m_axi_rresp  = rresp_cfg;
                bus.m_axi_rlast  = 1'b1;
                if (bus.m_axi_rvalid && bus.m_axi_rready) r_pend = 0;
                else r_wait++;
            end else begin
                bus.m_axi_rvalid = 1'b0;
            end
            // AW channel
            if (bus.m_axi_awvalid && !aw_got) begin
                bus.m_axi_awready = (aw_wait >= aw_delay);
                if (bus.m_axi_awready) begin
                    aw_got = 1; aw_wait = 0; aw_count++; aw_cyc = cyc; prev_aw_hs = 1;
                    cap_awaddr = bus.m_axi_awaddr;
                    cap_awmeta = {6'b0, bus.m_axi_awlen, bus.m_axi_awsize, bus.m_axi_awburst,
                                  bus.m_axi_awlock, bus.m_axi_awcache, bus.m_axi_awprot,
                                  bus.m_axi_awqos, bus.m_axi_awid};
                end else aw_wait++;
            end else begin
                bus.m_axi_awready = 1'b0;
            end
            // W channel
            if (bus.m_axi_wvalid && !w_got) begin
                bus.m_axi_wready = (w_wait >= w_delay);
                if (bus.m_axi_wready) begin
                    w_got = 1; w_wait = 0; w_count++; w_cyc = cyc; prev_w_hs = 1;
                    cap_wdata = bus.m_axi_wdata; cap_wstrb = bus.m_axi_wstrb;
                    cap_wlast = bus.m_axi_wlast;
                end else w_wait++;
            end else begin
                bus.m_axi_wready = 1'b0;
            end
            if (aw_got && w_got) begin
                mem[int'(cap_awaddr[29:2])] = merge(rd_mem(int'(cap_awaddr[29:2])), cap_wdata, cap_wstrb);
                aw_got = 0; w_got = 0; b_pend = 1; b_wait = 0;
            end
            // AR channel
            if (bus.m_axi_arvalid) begin
                bus.m_axi_arready = (ar_wait >= ar_delay);
                if (bus.m_axi_arready) begin
                    ar_wait = 0; ar_count++; prev_ar_hs = 1; r_pend = 1; r_wait = 0;
                    cap_araddr = bus.m_axi_araddr; r_addr = bus.m_axi_araddr;
                    cap_armeta = {6'b0, bus.m_axi_arlen, bus.m_axi_arsize, bus.m_axi_arburst,
                                  bus.m_axi_arlock, bus.m_axi_arcache, bus.m_axi_arprot,
                                  bus.m_axi_arqos, bus.m_axi_arid};
                end else ar_wait++;
            end else begin
                bus.m_axi_arready = 1'b0;
            end
            prev_awv = bus.m_axi_awvalid; prev_awaddr = bus.m_axi_awaddr;
            prev_wv = bus.m_axi_wvalid; prev_wdata = bus.m_axi_wdata; prev_wstrb = bus.m_axi_wstrb;
            prev_arv = bus.m_axi_arvalid; prev_araddr = bus.m_axi_araddr;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One native transaction; lat counts falling edges from request to ready.
    task automatic do_req(input bit wr, input logic [29:0] a, input logic [31:0] d,
                          input logic [3:0] s, input bit hold,
                          output logic [31:0] rd, output int lat);
        bus.req_valid = 1'b1; bus.req_addr = a; bus.req_wdata = d;
        bus.req_wstrb = wr ? s : 4'h0;
        lat = -1; rd = 32'h0;
        for (int c = 1; c <= 64; c++) begin
            @(negedge clk); #1;
            if (bus.req_ready) begin lat = c; rd = bus.req_rdata; break; end
        end
        if (lat < 0) chk("req_timeout", 64'd0, 64'd1);
        if (!hold) bus.req_valid = 1'b0;
        @(negedge clk); #1;
        chk("ready_pulse", bus.req_ready, 1'b0);
        if (hold) begin
            chk("no_reissue", {bus.m_axi_arvalid, bus.m_axi_awvalid}, 2'b00);
            bus.req_valid = 1'b0;
        end
        $display("txn %s addr=%h wdata=%h wstrb=%h rdata=%h lat=%0d",
                 wr ? "WR" : "RD", a, d, s, rd, lat);
    endtask

    typedef struct {
        bit          wr;
        logic [29:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        int          aw_d, w_d, b_d, ar_d, r_d;
        logic [31:0] exp_rdata;
        int          exp_lat;
    } vec_t;

    localparam logic [31:0] META_EXP = {6'b0, 8'h00, 3'd2, 2'b01, 1'b0, 4'b0011, 3'b010, 4'h0, 1'b0};

    vec_t        vecs [11];
    logic [31:0] ref_mem [int];
    logic [31:0] rd, exp_rd;
    int          lat, exp_lat, aw0, w0, ar0, n;
    bit          wr;
    logic [29:0] a;
    logic [31:0] d;
    logic [3:0]  s;

    initial begin
        vecs[0]  = '{1'b1, 30'h104, 32'hDEADBEEF, 4'hF, 0, 0, 0, 0, 0, 32'h0, 3};
        vecs[1]  = '{1'b0, 30'h104, 32'h0,        4'h0, 0, 0, 0, 0, 0, 32'hDEADBEEF, 3};
        vecs[2]  = '{1'b1, 30'h200, 32'hDEADBEEF, 4'hF, 0, 0, 0, 0, 0, 32'h0, 3};
        vecs[3]  = '{1'b1, 30'h200, 32'h0000CAFE, 4'h3, 0, 0, 0, 0, 0, 32'h0, 3};
        vecs[4]  = '{1'b0, 30'h203, 32'h0,        4'h0, 0, 0, 0, 0, 0, 32'hDEADCAFE, 3};
        vecs[5]  = '{1'b1, 30'h300, 32'h11223344, 4'hF, 3, 1, 0, 0, 0, 32'h0, 6};
        vecs[6]  = '{1'b0, 30'h300, 32'h0,        4'h0, 0, 0, 0, 0, 2, 32'h11223344, 5};
        vecs[7]  = '{1'b1, 30'h300, 32'hAABBCCDD, 4'h8, 0, 0, 2, 0, 0, 32'h0, 5};
        vecs[8]  = '{1'b0, 30'h302, 32'h0,        4'h0, 0, 0, 0, 1, 0, 32'hAA223344, 4};
        vecs[9]  = '{1'b1, 30'h010, 32'h00050000, 4'h4, 2, 2, 0, 0, 0, 32'h0, 5};
        vecs[10] = '{1'b0, 30'h010, 32'h0,        4'h0, 0, 0, 0, 0, 0, 32'h00050000, 3};

        rst = 1'b1;
        bus.req_valid = 1'b0; bus.req_addr = '0; bus.req_wdata = '0; bus.req_wstrb = '0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_req_ready", bus.req_ready, 1'b0);
        chk("rst_req_rdata", bus.req_rdata, 32'h0);
        chk("rst_err", {bus.err, bus.err_addr}, 31'h0);
        chk("rst_valids", {bus.m_axi_awvalid, bus.m_axi_wvalid, bus.m_axi_arvalid}, 3'b000);
        chk("rst_readies", {bus.m_axi_bready, bus.m_axi_rready}, 2'b00);
        rst = 1'b0;

        // directed table
        for (int i = 0; i < 11; i++) begin
            aw_delay = vecs[i].aw_d; w_delay = vecs[i].w_d; b_delay = vecs[i].b_d;
            ar_delay = vecs[i].ar_d; r_delay = vecs[i].r_d;
            aw0 = aw_count; w0 = w_count; ar0 = ar_count;
            do_req(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].wstrb, 1'b0, rd, lat);
            chk($sformatf("v%0d_lat", i), lat, vecs[i].exp_lat);
            if (vecs[i].wr) begin
                ref_mem[int'(vecs[i].addr[29:2])] = merge(ref_mem.exists(int'(vecs[i].addr[29:2])) ?
                    ref_mem[int'(vecs[i].addr[29:2])] : 32'h0, vecs[i].wdata, vecs[i].wstrb);
                chk($sformatf("v%0d_awaddr", i), cap_awaddr, {vecs[i].addr[29:2], 2'b00});
                chk($sformatf("v%0d_w", i), {cap_wlast, cap_wstrb, cap_wdata},
                    {1'b1, vecs[i].wstrb, vecs[i].wdata});
                chk($sformatf("v%0d_awmeta", i), cap_awmeta, META_EXP);
                chk($sformatf("v%0d_counts", i), {aw_count - aw0, w_count - w0, ar_count - ar0}, {32'd1, 32'd1, 32'd0});
            end else begin
                chk($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rdata);
                chk($sformatf("v%0d_araddr", i), cap_araddr, {vecs[i].addr[29:2], 2'b00});
                chk($sformatf("v%0d_armeta", i), cap_armeta, META_EXP);
                chk($sformatf("v%0d_counts", i), {aw_count - aw0, w_count - w0, ar_count - ar0}, {32'd0, 32'd0, 32'd1});
            end
            chk($sformatf("v%0d_proto", i), proto_err, 0);
        end

        // W completes before AW; each valid drops after its own handshake
        aw_delay = 3; w_delay = 1; b_delay = 0; ar_delay = 0; r_delay = 0;
        do_req(1'b1, 30'h3F0, 32'h12345678, 4'hF, 1'b0, rd, lat);
        ref_mem[int'(30'h3F0 >> 2)] = 32'h12345678;
        chk("bp_lat", lat, 6);
        chk("bp_w_before_aw", w_cyc < aw_cyc, 1'b1);
        chk("bp_proto", proto_err, 0);

        // slow read with req_valid held through DONE: one AR, one ready pulse
        aw_delay = 0; w_delay = 0; r_delay = 5;
        ar0 = ar_count;
        do_req(1'b0, 30'h3F0, 32'h0, 4'h0, 1'b1, rd, lat);
        repeat (3) @(negedge clk);
        #1;
        chk("hold_lat", lat, 8);
        chk("hold_rdata", rd, 32'h12345678);
        chk("hold_ar_count", ar_count - ar0, 1);
        r_delay = 0;

        // randomized traffic against the reference memory
        for (int i = 0; i < 40; i++) begin
            wr = 1'($urandom_range(0, 1));
            a  = 30'h1000 + 30'($urandom_range(0, 15) * 4) + 30'($urandom_range(0, 3));
            d  = $urandom;
            s  = 4'($urandom_range(1, 15));
            aw_delay = $urandom_range(0, 3); w_delay = $urandom_range(0, 3);
            b_delay  = $urandom_range(0, 3); ar_delay = $urandom_range(0, 3);
            r_delay  = $urandom_range(0, 3);
            exp_lat = wr ? 3 + ((aw_delay > w_delay) ? aw_delay : w_delay) + b_delay
                         : 3 + ar_delay + r_delay;
            exp_rd = ref_mem.exists(int'(a[29:2])) ? ref_mem[int'(a[29:2])] : 32'h0;
            do_req(wr, a, d, s, 1'b0, rd, lat);
            chk($sformatf("r%0d_lat", i), lat, exp_lat);
            if (wr) begin
                ref_mem[int'(a[29:2])] = merge(exp_rd, d, s);
                chk($sformatf("r%0d_wr", i), {cap_awaddr, cap_wstrb, cap_wdata}, {a[29:2], 2'b00, s, d});
            end else begin
                chk($sformatf("r%0d_rdata", i), rd, exp_rd);
            end
        end
        chk("rand_proto", proto_err, 0);
        aw_delay = 0; w_delay = 0; b_delay = 0; ar_delay = 0; r_delay = 0;

        // error capture: first error is the read at 0x40
        rresp_cfg = 2'b10;
        do_req(1'b0, 30'h40, 32'h0, 4'h0, 1'b0, rd, lat);
        rresp_cfg = 2'b00;
        chk("err_after_rd", {bus.err, bus.err_addr}, {ERR_ON, ERR_ON ? 30'h40 : 30'h0});
        chk("err_rd_lat", lat, 3);
        bresp_cfg = 2'b11;
        do_req(1'b1, 30'h80, 32'h55AA55AA, 4'hF, 1'b0, rd, lat);
        bresp_cfg = 2'b00;
        chk("err_after_wr", {bus.err, bus.err_addr}, {ERR_ON, ERR_ON ? 30'h40 : 30'h0});
        chk("err_wr_lat", lat, 3);

        // reset while waiting for the write response
        b_delay = 20;
        bus.req_valid = 1'b1; bus.req_addr = 30'h500; bus.req_wdata = 32'h0BADF00D; bus.req_wstrb = 4'hF;
        n = 0;
        do begin
            @(negedge clk); #1; n++;
        end while (!bus.m_axi_bready && n < 30);
        chk("reach_wresp", bus.m_axi_bready, 1'b1);
        bus.req_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("rstmid_outputs", {bus.m_axi_bready, bus.m_axi_awvalid, bus.m_axi_wvalid, bus.req_ready}, 4'b0000);
        chk("rstmid_err", {bus.err, bus.err_addr}, 31'h0);
        @(negedge clk); #1;
        rst = 1'b0;
        b_delay = 0;
        do_req(1'b0, 30'h104, 32'h0, 4'h0, 1'b0, rd, lat);
        chk("post_rst_rdata", rd, 32'hDEADBEEF);
        chk("post_rst_lat", lat, 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
